slot_write_bridge: RTL and testbench

Parametrised clock-enable generator and write-slot bridge that sits between the ROM loader and the SDRAM controller. It divides the system clock into DIV phases and decodes one phase as the core clock enable. Loader write strobes are buffered in a FIFO of FIFO_DEPTH entries, and at most one entry is issued per slot as a write held stable for a full DIV-cycle window. It generalises the fixed 4-phase, single-entry loader write handoff: divider, slot phase, buffer depth and widths are all configurable, and it adds overflow detection and flush.

---
 rtl/slot_write_bridge_if.sv | 44 ++++
 rtl/slot_write_bridge.sv | 122 ++++++++++++
 tb/tb_slot_write_bridge.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/slot_write_bridge_if.sv
`default_nettype none
// ============================================================================
//  Module      : slot_write_bridge_if
//  Description : Loader-side and SDRAM-side signal bundle for the write-slot
//                bridge, including phase/enable and FIFO status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface slot_write_bridge_if #(
    parameter int ADDR_W     = 22,
    parameter int DATA_W     = 8,
    parameter int DIV        = 4,
    parameter int FIFO_DEPTH = 4
);
    localparam int c_PHASE_W = $clog2(DIV);
    localparam int c_LEVEL_W = $clog2(FIFO_DEPTH) + 1;

    logic                 run;
    logic                 enable;
    logic                 wr_strobe;
    logic [ADDR_W-1:0]    wr_addr;
    logic [DATA_W-1:0]    wr_data;
    logic [c_PHASE_W-1:0] phase;
    logic                 ce;
    logic                 mem_we;
    logic [ADDR_W-1:0]    mem_addr;
    logic [DATA_W-1:0]    mem_data;
    logic [c_LEVEL_W-1:0] level;
    logic                 empty;
    logic                 full;
    logic                 overflow;

    // Loader / system side drives the requests and observes the bridge.
    modport master (
        output run, enable, wr_strobe, wr_addr, wr_data,
        input  phase, ce, mem_we, mem_addr, mem_data, level, empty, full, overflow
    );

    // The bridge itself.
    modport slave (
        input  run, enable, wr_strobe, wr_addr, wr_data,
        output phase, ce, mem_we, mem_addr, mem_data, level, empty, full, overflow
    );
endinterface
`default_nettype wire

// File: rtl/slot_write_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : slot_write_bridge
//  Description : Divides clk into DIV phases, decodes SLOT_PHASE as the core
//                clock enable, buffers loader writes in a FIFO and issues at
//                most one write per slot, held for a full DIV-cycle window.
//  Revision    : 1.0 - initial release
// ============================================================================
module slot_write_bridge #(
    parameter int ADDR_W     = 22,
    parameter int DATA_W     = 8,
    parameter int DIV        = 4,
    parameter int SLOT_PHASE = 3,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic          clk,
    input  wire logic          reset_n,
    slot_write_bridge_if.slave bus
);
    localparam int c_PHASE_W = $clog2(DIV);
    localparam int c_PTR_W   = $clog2(FIFO_DEPTH);
    localparam int c_LEVEL_W = c_PTR_W + 1;
    localparam int c_ENTRY_W = ADDR_W + DATA_W;

    logic [c_PHASE_W-1:0] r_phase;
    logic [c_ENTRY_W-1:0] r_fifo [FIFO_DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_LEVEL_W-1:0] r_level;
    logic                 r_mem_we;
    logic [ADDR_W-1:0]    r_mem_addr;
    logic [DATA_W-1:0]    r_mem_data;
    logic                 r_overflow;

    logic w_slot;
    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;
    logic w_drop;

    // Status is derived from the registered level, so it trails events by one cycle.
    assign w_slot  = (r_phase == c_PHASE_W'(SLOT_PHASE));
    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == c_LEVEL_W'(FIFO_DEPTH));
    // A pop frees the head slot in the same cycle, so a full FIFO still accepts.
    assign w_pop   = w_slot && bus.enable && !w_empty;
    assign w_push  = bus.wr_strobe && bus.enable && (!w_full || w_pop);
    assign w_drop  = bus.wr_strobe && bus.enable && w_full && !w_pop;

    assign bus.phase    = r_phase;
    assign bus.ce       = bus.run && w_slot;
    assign bus.mem_we   = r_mem_we;
    assign bus.mem_addr = r_mem_addr;
    assign bus.mem_data = r_mem_data;
    assign bus.level    = r_level;
    assign bus.empty    = w_empty;
    assign bus.full     = w_full;
    assign bus.overflow = r_overflow;

    // Free-running phase counter, independent of run and enable.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_phase <= '0;
        end else if (r_phase == c_PHASE_W'(DIV - 1)) begin
            r_phase <= '0;
        end else begin
            r_phase <= r_phase + c_PHASE_W'(1);
        end
    end

    // FIFO storage; the head is read combinationally, so a write to the same
    // slot on a full-FIFO pop cycle does not disturb the entry being issued.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo[r_wr_ptr] <= {bus.wr_addr, bus.wr_data};
        end
    end

    // Pointers, occupancy, overflow flag and the held SDRAM write window.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_mem_we   <= 1'b0;
            r_mem_addr <= '0;
            r_mem_data <= '0;
            r_overflow <= 1'b0;
        end else if (!bus.enable) begin
            // Flush: drop queue and any in-flight write; address/data lines hold.
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
            r_level    <= '0;
            r_mem_we   <= 1'b0;
            r_overflow <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_PTR_W'(1);
            end
            if (w_push && !w_pop) begin
                r_level <= r_level + c_LEVEL_W'(1);
            end else if (w_pop && !w_push) begin
                r_level <= r_level - c_LEVEL_W'(1);
            end
            if (w_drop) begin
                r_overflow <= 1'b1;
            end
            // Write outputs move only right after a slot, giving a DIV-cycle window.
            if (w_slot) begin
                r_mem_we <= w_pop;
                if (w_pop) begin
                    {r_mem_addr, r_mem_data} <= r_fifo[r_rd_ptr];
                end
            end
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_slot_write_bridge.sv
`default_nettype none
// ============================================================================
//  Module      : tb_slot_write_bridge
//  Description : Directed, table-driven bench for slot_write_bridge with the
//                default configuration plus a DIV=6 / depth-8 / wide instance.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_slot_write_bridge;
    logic clk = 1'b0;
    logic reset_n = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    slot_write_bridge_if #(.ADDR_W(22), .DATA_W(8), .DIV(4), .FIFO_DEPTH(4)) b1 ();
    slot_write_bridge_if #(.ADDR_W(24), .DATA_W(16), .DIV(6), .FIFO_DEPTH(8)) b2 ();

    slot_write_bridge #(
        .ADDR_W(22), .DATA_W(8), .DIV(4), .SLOT_PHASE(3), .FIFO_DEPTH(4)
    ) u_dut (
        .clk(clk), .reset_n(reset_n), .bus(b1.slave)
    );

    slot_write_bridge #(
        .ADDR_W(24), .DATA_W(16), .DIV(6), .SLOT_PHASE(0), .FIFO_DEPTH(8)
    ) u_dut_wide (
        .clk(clk), .reset_n(reset_n), .bus(b2.slave)
    );

    typedef struct {
        logic        stb;
        logic [21:0] addr;
        logic [7:0]  data;
        int          ph;
        logic        ce;
        logic        we;
        logic [21:0] maddr;
        logic [7:0]  mdata;
        int          lvl;
        logic        full;
        logic        ovf;
    } vec_t;

    vec_t tbl [25];

    function automatic vec_t mk(input logic stb, input logic [21:0] addr, input logic [7:0] data,
                                input int ph, input logic ce, input logic we,
                                input logic [21:0] maddr, input logic [7:0] mdata,
                                input int lvl, input logic full, input logic ovf);
        vec_t v;
        v.stb = stb; v.addr = addr; v.data = data; v.ph = ph; v.ce = ce; v.we = we;
        v.maddr = maddr; v.mdata = mdata; v.lvl = lvl; v.full = full; v.ovf = ovf;
        return v;
    endfunction

    task automatic chk(input string nm, input int c, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s cycle=%0d actual=0x%0h required=0x%0h", nm, c, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Holds reset for 3 edges; returns at the start of cycle 0 (phase 0).
    task automatic do_reset();
        reset_n = 1'b0;
        b1.wr_strobe = 1'b0;
        b2.wr_strobe = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    function automatic logic [15:0] wide_data(input int k);
        return 16'hF00F + 16'(k * 257);
    endfunction

    initial begin
        b1.run = 1'b0; b1.enable = 1'b1; b1.wr_strobe = 1'b0; b1.wr_addr = '0; b1.wr_data = '0;
        b2.run = 1'b0; b2.enable = 1'b1; b2.wr_strobe = 1'b0; b2.wr_addr = '0; b2.wr_data = '0;

        // Overflow burst table: strobes A..F on cycles 0..5, run=1.
        tbl[0]  = mk(1, 22'h00A01, 8'hA1, 0, 0, 0, 22'h0,     8'h00, 0, 0, 0);
        tbl[1]  = mk(1, 22'h00B02, 8'hB2, 1, 0, 0, 22'h0,     8'h00, 1, 0, 0);
        tbl[2]  = mk(1, 22'h00C03, 8'hC3, 2, 0, 0, 22'h0,     8'h00, 2, 0, 0);
        tbl[3]  = mk(1, 22'h00D04, 8'hD4, 3, 1, 0, 22'h0,     8'h00, 3, 0, 0);
        tbl[4]  = mk(1, 22'h00E05, 8'hE5, 0, 0, 1, 22'h00A01, 8'hA1, 3, 0, 0);
        tbl[5]  = mk(1, 22'h00F06, 8'hF6, 1, 0, 1, 22'h00A01, 8'hA1, 4, 1, 0);
        tbl[6]  = mk(0, 22'h0,     8'h00, 2, 0, 1, 22'h00A01, 8'hA1, 4, 1, 1);
        tbl[7]  = mk(0, 22'h0,     8'h00, 3, 1, 1, 22'h00A01, 8'hA1, 4, 1, 1);
        tbl[8]  = mk(0, 22'h0,     8'h00, 0, 0, 1, 22'h00B02, 8'hB2, 3, 0, 1);
        tbl[9]  = mk(0, 22'h0,     8'h00, 1, 0, 1, 22'h00B02, 8'hB2, 3, 0, 1);
        tbl[10] = mk(0, 22'h0,     8'h00, 2, 0, 1, 22'h00B02, 8'hB2, 3, 0, 1);
        tbl[11] = mk(0, 22'h0,     8'h00, 3, 1, 1, 22'h00B02, 8'hB2, 3, 0, 1);
        tbl[12] = mk(0, 22'h0,     8'h00, 0, 0, 1, 22'h00C03, 8'hC3, 2, 0, 1);
        tbl[13] = mk(0, 22'h0,     8'h00, 1, 0, 1, 22'h00C03, 8'hC3, 2, 0, 1);
        tbl[14] = mk(0, 22'h0,     8'h00, 2, 0, 1, 22'h00C03, 8'hC3, 2, 0, 1);
        tbl[15] = mk(0, 22'h0,     8'h00, 3, 1, 1, 22'h00C03, 8'hC3, 2, 0, 1);
        tbl[16] = mk(0, 22'h0,     8'h00, 0, 0, 1, 22'h00D04, 8'hD4, 1, 0, 1);
        tbl[17] = mk(0, 22'h0,     8'h00, 1, 0, 1, 22'h00D04, 8'hD4, 1, 0, 1);
        tbl[18] = mk(0, 22'h0,     8'h00, 2, 0, 1, 22'h00D04, 8'hD4, 1, 0, 1);
        tbl[19] = mk(0, 22'h0,     8'h00, 3, 1, 1, 22'h00D04, 8'hD4, 1, 0, 1);
        tbl[20] = mk(0, 22'h0,     8'h00, 0, 0, 1, 22'h00E05, 8'hE5, 0, 0, 1);
        tbl[21] = mk(0, 22'h0,     8'h00, 1, 0, 1, 22'h00E05, 8'hE5, 0, 0, 1);
        tbl[22] = mk(0, 22'h0,     8'h00, 2, 0, 1, 22'h00E05, 8'hE5, 0, 0, 1);
        tbl[23] = mk(0, 22'h0,     8'h00, 3, 1, 1, 22'h00E05, 8'hE5, 0, 0, 1);
        tbl[24] = mk(0, 22'h0,     8'h00, 0, 0, 0, 22'h00E05, 8'hE5, 0, 0, 1);

        // ---- Reset values, then phase sequence with run=0 and run=1 ----
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_phase", 0, 32'(b1.phase), 32'd0);
        chk("rst_ce", 0, 32'(b1.ce), 32'd0);
        chk("rst_we", 0, 32'(b1.mem_we), 32'd0);
        chk("rst_addr", 0, 32'(b1.mem_addr), 32'd0);
        chk("rst_data", 0, 32'(b1.mem_data), 32'd0);
        chk("rst_level", 0, 32'(b1.level), 32'd0);
        chk("rst_empty", 0, 32'(b1.empty), 32'd1);
        chk("rst_full", 0, 32'(b1.full), 32'd0);
        chk("rst_ovf", 0, 32'(b1.overflow), 32'd0);
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        for (int c = 0; c < 16; c++) begin
            b1.run = (c >= 8);
            @(negedge clk);
            chk("phase_seq", c, 32'(b1.phase), 32'(c % 4));
            chk("ce_decode", c, 32'(b1.ce), 32'((c >= 8) && (c % 4 == 3)));
            step();
        end

        // ---- Overflow burst (table driven) ----
        b1.run = 1'b1;
        do_reset();
        for (int i = 0; i < 25; i++) begin
            b1.wr_strobe = tbl[i].stb;
            b1.wr_addr   = tbl[i].addr;
            b1.wr_data   = tbl[i].data;
            @(negedge clk);
            chk("tbl_phase", i, 32'(b1.phase), 32'(tbl[i].ph));
            chk("tbl_ce", i, 32'(b1.ce), 32'(tbl[i].ce));
            chk("tbl_we", i, 32'(b1.mem_we), 32'(tbl[i].we));
            chk("tbl_addr", i, 32'(b1.mem_addr), 32'(tbl[i].maddr));
            chk("tbl_data", i, 32'(b1.mem_data), 32'(tbl[i].mdata));
            chk("tbl_level", i, 32'(b1.level), 32'(tbl[i].lvl));
            chk("tbl_full", i, 32'(b1.full), 32'(tbl[i].full));
            chk("tbl_ovf", i, 32'(b1.overflow), 32'(tbl[i].ovf));
            step();
        end
        // Flush clears the sticky overflow; address/data hold.
        b1.wr_strobe = 1'b1;
        b1.wr_addr   = 22'h3FFFF;
        b1.enable    = 1'b0;
        step();
        b1.wr_strobe = 1'b0;
        b1.enable    = 1'b1;
        @(negedge clk);
        chk("flush_ovf_clr", 26, 32'(b1.overflow), 32'd0);
        chk("flush_addr_hold", 26, 32'(b1.mem_addr), 32'h00E05);
        chk("flush_level_a", 26, 32'(b1.level), 32'd0);
        step();

        // ---- Single write: strobe at cycle 0 ----
        do_reset();
        for (int c = 0; c < 10; c++) begin
            b1.wr_strobe = (c == 0);
            b1.wr_addr   = 22'h00123;
            b1.wr_data   = 8'hA5;
            @(negedge clk);
            if (c == 1) chk("sw_level1", c, 32'(b1.level), 32'd1);
            if (c >= 4) chk("sw_level0", c, 32'(b1.level), 32'd0);
            if (c >= 4 && c <= 7) begin
                chk("sw_we", c, 32'(b1.mem_we), 32'd1);
                chk("sw_addr", c, 32'(b1.mem_addr), 32'h00123);
                chk("sw_data", c, 32'(b1.mem_data), 32'hA5);
            end
            if (c < 4 || c >= 8) chk("sw_we0", c, 32'(b1.mem_we), 32'd0);
            step();
        end

        // ---- Full FIFO plus strobe on the slot cycle ----
        do_reset();
        for (int c = 0; c < 25; c++) begin
            b1.wr_strobe = (c <= 4) || (c == 7);
            b1.wr_addr   = 22'(32'h100 + c);
            b1.wr_data   = 8'(c);
            @(negedge clk);
            if (c == 6) begin
                chk("fp_level_full", c, 32'(b1.level), 32'd4);
                chk("fp_full", c, 32'(b1.full), 32'd1);
            end
            if (c == 8) begin
                chk("fp_level_kept", c, 32'(b1.level), 32'd4);
                chk("fp_full_kept", c, 32'(b1.full), 32'd1);
                chk("fp_no_ovf", c, 32'(b1.overflow), 32'd0);
                chk("fp_pop_addr", c, 32'(b1.mem_addr), 32'h101);
            end
            if (c == 24) begin
                chk("fp_last_addr", c, 32'(b1.mem_addr), 32'h107);
                chk("fp_last_data", c, 32'(b1.mem_data), 32'h07);
                chk("fp_last_we", c, 32'(b1.mem_we), 32'd1);
                chk("fp_ovf_end", c, 32'(b1.overflow), 32'd0);
            end
            step();
        end

        // ---- Flush with 3 queued entries and an active write ----
        do_reset();
        for (int c = 0; c < 13; c++) begin
            b1.wr_strobe = (c <= 4);
            b1.wr_addr   = (c == 4) ? 22'h3FF : 22'(32'h200 + c);
            b1.wr_data   = 8'(8'h40 + c);
            b1.enable    = (c != 4);
            @(negedge clk);
            if (c == 4) begin
                chk("fl_pre_level", c, 32'(b1.level), 32'd3);
                chk("fl_pre_we", c, 32'(b1.mem_we), 32'd1);
            end
            if (c == 5) begin
                chk("fl_empty", c, 32'(b1.empty), 32'd1);
                chk("fl_full", c, 32'(b1.full), 32'd0);
                chk("fl_ovf", c, 32'(b1.overflow), 32'd0);
                chk("fl_addr_hold", c, 32'(b1.mem_addr), 32'h200);
                chk("fl_data_hold", c, 32'(b1.mem_data), 32'h40);
            end
            if (c >= 5) begin
                chk("fl_we0", c, 32'(b1.mem_we), 32'd0);
                chk("fl_level0", c, 32'(b1.level), 32'd0);
            end
            step();
        end
        b1.enable = 1'b1;

        // ---- Parameter sweep: DIV=6, SLOT_PHASE=0, depth 8, 24/16 bit ----
        b2.run = 1'b1;
        do_reset();
        for (int c = 0; c < 63; c++) begin
            b2.wr_strobe = (c <= 9);
            b2.wr_addr   = 24'(32'hC00000 + c);
            b2.wr_data   = wide_data(c);
            @(negedge clk);
            chk("pw_phase", c, 32'(b2.phase), 32'(c % 6));
            chk("pw_ce", c, 32'(b2.ce), 32'(c % 6 == 0));
            if (c == 9) begin
                chk("pw_level8", c, 32'(b2.level), 32'd8);
                chk("pw_no_ovf_yet", c, 32'(b2.overflow), 32'd0);
            end
            if (c == 10) begin
                chk("pw_full", c, 32'(b2.full), 32'd1);
                chk("pw_ovf", c, 32'(b2.overflow), 32'd1);
                chk("pw_level_drop", c, 32'(b2.level), 32'd8);
            end
            if (c >= 7 && c <= 60) begin
                chk("pw_we", c, 32'(b2.mem_we), 32'd1);
                chk("pw_addr", c, 32'(b2.mem_addr), 32'hC00000 + 32'((c - 7) / 6));
                chk("pw_data", c, 32'(b2.mem_data), 32'(wide_data((c - 7) / 6)));
            end else begin
                chk("pw_we0", c, 32'(b2.mem_we), 32'd0);
            end
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
`default_nettype wire
